// File: rtl/mcu_quad_gen.sv
// Mouse-to-quadrature generator: accumulates signed movement reports and replays
// them as A/B quadrature steps paced by the MCU clock enable, plus a synchronised button.
module mcu_quad_gen #(
    parameter int STEP_DIV = 64,
    parameter int ACCW     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       mouse_strobe,
    input  logic [8:0] mouse_dx,
    input  logic [8:0] mouse_dy,
    input  logic       mouse_btn,
    input  logic       flush,
    output logic       x_a,
    output logic       x_b,
    output logic       y_a,
    output logic       y_b,
    output logic       btn_n,
    output logic       busy
);

    // Sum width leaves headroom so acc + delta - step never wraps before saturation.
    localparam int SW = ((ACCW > 9) ? ACCW : 9) + 2;
    localparam logic signed [SW-1:0] ACC_MAX = SW'((2 ** (ACCW - 1)) - 1);
    localparam logic signed [SW-1:0] ACC_MIN = SW'(-(2 ** (ACCW - 1)));
    localparam logic signed [SW-1:0] S_ZERO  = SW'(1'b0);
    localparam logic signed [SW-1:0] S_POS1  = SW'(1'b1);
    localparam logic signed [SW-1:0] S_NEG1  = -S_POS1;

    logic [7:0]             cnt_r;
    logic                   tick_s;
    logic signed [ACCW-1:0] acc_x_r, acc_y_r;
    logic signed [ACCW-1:0] acc_x_nxt_s, acc_y_nxt_s;
    logic signed [SW-1:0]   step_x_s, step_y_s;
    logic                   btn_sync_r;

    function automatic logic signed [SW-1:0] axis_step(input logic signed [ACCW-1:0] acc,
                                                       input logic en);
        logic signed [SW-1:0] s;
        if (!en || (acc == '0)) s = S_ZERO;
        else if (acc[ACCW-1])   s = S_NEG1;
        else                    s = S_POS1;
        return s;
    endfunction

    function automatic logic signed [ACCW-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [ACCW-1:0] r;
        if (v > ACC_MAX)      r = ACC_MAX[ACCW-1:0];
        else if (v < ACC_MIN) r = ACC_MIN[ACCW-1:0];
        else                  r = v[ACCW-1:0];
        return r;
    endfunction

    function automatic logic signed [ACCW-1:0] acc_next(input logic signed [ACCW-1:0] acc,
                                                        input logic signed [SW-1:0] step,
                                                        input logic strobe,
                                                        input logic [8:0] delta,
                                                        input logic clr);
        logic signed [SW-1:0] d;
        logic signed [SW-1:0] sum;
        d   = strobe ? SW'($signed(delta)) : S_ZERO;
        sum = SW'(acc) + d - step;
        if (clr) return '0;
        else     return sat(sum);
    endfunction

    // Forward order is 00->01->11->10; {a,b} packed as [1]=a, [0]=b.
    function automatic logic [1:0] phase_next(input logic [1:0] ab,
                                              input logic signed [SW-1:0] step);
        logic [1:0] r;
        if (step == S_ZERO)  r = ab;
        else if (step[SW-1]) r = {~ab[0], ab[1]};
        else                 r = {ab[0], ~ab[1]};
        return r;
    endfunction

    assign tick_s = cen && (cnt_r == 8'(STEP_DIV - 1));
    assign busy   = (acc_x_r != '0) || (acc_y_r != '0);

    // Per-axis step direction and next accumulator value.
    always_comb begin
        step_x_s    = axis_step(acc_x_r, tick_s);
        step_y_s    = axis_step(acc_y_r, tick_s);
        acc_x_nxt_s = acc_next(acc_x_r, step_x_s, mouse_strobe, mouse_dx, flush);
        acc_y_nxt_s = acc_next(acc_y_r, step_y_s, mouse_strobe, mouse_dy, flush);
    end

    // Step divider, accumulators, quadrature phases and button synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= 8'd0;
            acc_x_r    <= '0;
            acc_y_r    <= '0;
            x_a        <= 1'b0;
            x_b        <= 1'b0;
            y_a        <= 1'b0;
            y_b        <= 1'b0;
            btn_sync_r <= 1'b0;
            btn_n      <= 1'b1;
        end else begin
            if (cen) cnt_r <= tick_s ? 8'd0 : cnt_r + 8'd1;
            else     cnt_r <= cnt_r;
            acc_x_r    <= acc_x_nxt_s;
            acc_y_r    <= acc_y_nxt_s;
            {x_a, x_b} <= phase_next({x_a, x_b}, step_x_s);
            {y_a, y_b} <= phase_next({y_a, y_b}, step_y_s);
            btn_sync_r <= mouse_btn;
            btn_n      <= ~btn_sync_r;
        end
    end

endmodule

// File: doc/mcu_quad_gen.md
MCU_QUAD_GEN -- requirements
Module: mcu_quad_gen

Interface
REQ-001 Parameter STEP_DIV, default 64: number of cen pulses per quadrature step tick (range 2..255).
REQ-002 Parameter ACCW, default 10: width of each signed axis accumulator.
REQ-003 clk  input  1  system clock, the only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cen  input  1  clock enable, the same pulse that drives the 6805 MCU.
REQ-006 mouse_strobe  input  1  one-clk pulse marking a new movement report.
REQ-007 mouse_dx  input  9  signed X delta, two's complement, sampled on mouse_strobe.
REQ-008 mouse_dy  input  9  signed Y delta, sampled on mouse_strobe.
REQ-009 mouse_btn  input  1  button pressed, active-high, asynchronous to clk.
REQ-010 flush  input  1  zeroes both accumulators.
REQ-011 x_a, x_b  output  1 each  X-axis quadrature pair, registered; feeds MCU pa_in.
REQ-012 y_a, y_b  output  1 each  Y-axis quadrature pair, registered; feeds MCU pa_in.
REQ-013 btn_n  output  1  button, active-low, registered.
REQ-014 busy  output  1  high while either accumulator is nonzero.

Function
REQ-015 The step counter shall increment on each cen pulse and wrap from STEP_DIV-1 to 0.
REQ-016 The wrap cycle shall assert an internal one-clk step tick; the tick is never asserted without cen.
REQ-017 On a tick, an axis with acc>0 shall advance its phase forward and decrement acc by 1.
REQ-018 Forward phase sequence for (a,b): 00 -> 01 -> 11 -> 10 -> 00.
REQ-019 On a tick, an axis with acc<0 shall step its phase in reverse order and increment acc by 1.
REQ-020 On a tick, an axis with acc=0 shall hold its phase and accumulator.
REQ-021 X and Y shall step independently on the same tick; at most one phase transition per axis per tick.
REQ-022 On mouse_strobe, each accumulator shall add the sign-extended delta.
REQ-023 The result shall saturate to [-(2^(ACCW-1)), 2^(ACCW-1)-1], i.e. [-512, 511] at default; no wrap-around.
REQ-024 Strobe and tick in the same cycle: acc_next = sat(acc + delta - step), with step = sign(acc) evaluated on the pre-update acc; the phase moves per that step.
REQ-025 Saturation in REQ-024 shall be applied once, to the full-precision sum.
REQ-026 flush shall clear both accumulators on the next edge and override a simultaneous strobe; a phase step on that cycle still occurs, and phases are not reset.
REQ-027 mouse_btn shall pass through a 2-flop synchronizer; btn_n = inverted synchronizer output, 2-clk latency.
REQ-028 busy shall be derived from the registered accumulators (0 latency from acc state).
REQ-029 Quadrature outputs change only on tick cycles; no glitches between ticks.

Reset
REQ-030 While rst=1 on an edge: accumulators=0, step counter=0, phases x=00 and y=00, synchronizer flops=0, btn_n=1, busy=0.
REQ-031 Reset mid-operation discards pending movement; the first tick after release occurs STEP_DIV cen pulses later.
REQ-032 rst shall take priority over strobe, flush and tick.

Verification
REQ-033 Reset, then strobe dx=+3, dy=0 -> over 3 ticks x(a,b) = 01, 11, 10 and then holds; y stays 00; busy falls after the 3rd tick.
REQ-034 Strobe dx=-2 from phase 00 -> x(a,b) = 10, then 11; acc reaches 0.
REQ-035 Strobes of +255 twice, then +255 again, with no ticks -> acc_x = 511 (saturated); after one tick, acc_x = 510.
REQ-036 acc_x=+1 with a strobe of dx=-5 on a tick cycle -> acc_x = -5 and the phase moves forward once.
REQ-037 acc_x=+40, assert flush with a simultaneous strobe of dx=+7 -> acc_x = 0 and busy=0 the next cycle.
REQ-038 mouse_btn 0->1 -> btn_n falls exactly 2 clk later; rst asserted mid-stream -> all outputs return to REQ-030 values on the next edge.
